alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth in entries; power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  command offered.
REQ-007 in_ready  output  1  command FIFO can accept.
REQ-008 in_op  input  3  opcode: 0 plus, 1 minus, 2 and, 3 or, 4 negate a.
REQ-009 in_a, in_b  input  WIDTH  operands.
REQ-010 in_use_acc  input  1  replace in_a with the accumulator at execution.
REQ-011 alu_a, alu_b  output  WIDTH  operands driven to the downstream ALU.
REQ-012 alu_opcode  output  3  opcode driven to the downstream ALU.
REQ-013 alu_out  input  WIDTH  combinational ALU result.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 res_data  output  WIDTH  registered result.
REQ-017 res_err  output  1  result came from an illegal opcode (5-7).

Function
REQ-018 Push SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal not-full, with no bypass from a same-cycle pop.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; the occupancy count SHALL range 0..DEPTH.
REQ-020 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-021 IDLE: if the FIFO is non-empty, pop the head into the operand registers and go to EXEC.
REQ-022 EXEC (exactly one cycle): drive the operand registers onto alu_*, capture res_data and res_err at the cycle end, set res_valid, and go to RESP.
REQ-023 RESP: res_valid, res_data and res_err SHALL hold stable until res_ready is high.
REQ-024 On the RESP handshake, pop the next entry and go to EXEC if the FIFO is non-empty, else go to IDLE; this gives back-to-back throughput of one result per 2 cycles.
REQ-025 Latency SHALL be 2 cycles: a command pushed at edge N into an empty FIFO with the FSM in IDLE gives res_valid high after edge N+2.
REQ-026 alu_a SHALL be the accumulator when the popped in_use_acc is set, else the latched in_a.
REQ-027 alu_a, alu_b and alu_opcode SHALL be 0 outside EXEC.
REQ-028 The accumulator SHALL load the captured res_data on each legal-opcode capture.
REQ-029 For opcodes 5-7: res_err SHALL be 1, res_data SHALL be 0, the accumulator SHALL not change, and alu_out SHALL be ignored.
REQ-030 Arithmetic SHALL be modulo 2^WIDTH; carry and borrow SHALL be discarded.
REQ-031 Commands SHALL complete strictly in acceptance order; no command SHALL be dropped or duplicated.

Reset
REQ-032 On rst_n low, asynchronously: FIFO empty, FSM in IDLE, accumulator 0, res_valid 0, res_data 0, res_err 0, alu_* 0, in_ready 1.
REQ-033 Reset asserted mid-EXEC or mid-RESP SHALL discard all in-flight and queued commands.

Structure
REQ-034 Opcode constants (OP_PLUS..OP_UNEGATE) and the FSM state encoding SHALL live in shared package alu_pkg, reused by the ALU.
REQ-035 The FIFO SHALL be sub-module alu_cmd_fifo, parameterised by DEPTH and entry width; the ALU itself SHALL be instantiated by the parent, not inside this block.

Verification
REQ-036 Reset scenario: reset pulse -> in_ready=1, res_valid=0, accumulator 0.
REQ-037 Plus scenario: op 0, a=8'h0F, b=8'h01 -> res_data=8'h10, res_err=0, res_valid 2 cycles after accept.
REQ-038 Wrap scenario: 8'hFF+8'h02 -> 8'h01; then minus 8'h00-8'h01 -> 8'hFF.
REQ-039 Back-pressure scenario: res_ready=0, offer 6 commands -> 5 accepted (1 held plus 4 queued), in_ready low on the 6th; release res_ready -> results in order, one every 2 cycles.
REQ-040 Accumulator scenario: plus 3,4 -> 7; then use_acc minus b=2 -> 5; then illegal op 6 -> res_err=1, res_data=0, next use_acc plus b=0 -> 5.
REQ-041 Reset mid-RESP with 3 queued -> res_valid=0 at once; no stale result ever appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice and the downstream ALU.
// Contents: opcode constants, the issue FSM state type and an opcode
// legality helper.
package alu_pkg;

  localparam logic [2:0] OP_PLUS    = 3'd0;
  localparam logic [2:0] OP_MINUS   = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_UNEGATE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes above OP_UNEGATE are reserved and flagged as errors.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_UNEGATE);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_issue.
// Ports: clk, rst_n (async active-low), push/push_data (write side),
// pop/pop_data (read side, pop_data shows the head combinationally),
// empty, full. Pushes while full and pops while empty are ignored.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               empty,
  output logic               full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU command issue stage.
// Queues commands (opcode, operands, accumulator select) in a FIFO, issues
// one at a time to an external combinational ALU for exactly one cycle,
// registers the result and holds it until the consumer accepts it.
// Ports: clk, rst_n; in_valid/in_ready/in_op/in_a/in_b/in_use_acc (command
// input); alu_a/alu_b/alu_opcode (to ALU, zero outside EXEC), alu_out (from
// ALU); res_valid/res_ready/res_data/res_err (result output).
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  localparam int unsigned EW = 2*WIDTH + 4;

  state_t           state;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;
  logic             empty;
  logic             full;
  logic             pop;
  logic             op_use_acc;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;

  assign push_data = {in_use_acc, in_op, in_a, in_b};
  assign in_ready  = ~full;

  // Pop on leaving IDLE or on a RESP handshake with more work queued.
  assign pop = ~empty & ((state == ST_IDLE) | ((state == ST_RESP) & res_ready));

  alu_cmd_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_use_acc <= 1'b0;
      op_code    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            {op_use_acc, op_code, op_a, op_b} <= head;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_valid <= 1'b1;
          if (op_legal(op_code)) begin
            res_data <= alu_out;
            res_err  <= 1'b0;
            acc      <= alu_out;
          end else begin
            res_data <= '0;
            res_err  <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!empty) begin
              {op_use_acc, op_code, op_a, op_b} <= head;
              state <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    if (state == ST_EXEC) begin
      alu_a      = op_use_acc ? acc : op_a;
      alu_b      = op_b;
      alu_opcode = op_code;
    end
  end

endmodule
